// File: rtl/asrv32_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory access and writeback
// all resolve combinationally; PC and register file update on the rising edge.
module asrv32_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_inst,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_data_from_memory,
  output logic [31:0] o_store_data,
  output logic [31:0] o_store_data_addr,
  output logic [3:0]  o_wr_mask,
  output logic        o_wr_en
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        br_taken;

  logic [31:0] mem_addr;
  logic [1:0]  byte_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_res;
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  logic        rd_we;
  logic [31:0] rd_wdata;

  assign opcode = i_inst[6:0];
  assign rd     = i_inst[11:7];
  assign funct3 = i_inst[14:12];
  assign rs1    = i_inst[19:15];
  assign rs2    = i_inst[24:20];
  assign alt    = i_inst[30];

  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {i_inst[31:12], 12'h000};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // x0 is never written, so its flop stays at the reset value of zero
  assign rs1_val = regs_q[rs1];
  assign rs2_val = regs_q[rs2];

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = (opcode == OPC_OP && alt) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_res = rs1_val << shamt;
      3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'b0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: begin
        if (alt) alu_res = $signed(rs1_val) >>> shamt;
        else     alu_res = rs1_val >> shamt;
      end
      3'b110: alu_res = rs1_val | alu_b;
      3'b111: alu_res = rs1_val & alu_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // One adder serves load/store addressing and the JALR target
  assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign byte_off = mem_addr[1:0];

  always_comb begin
    ld_byte = i_data_from_memory[{byte_off, 3'b000} +: 8];
    ld_half = byte_off[1] ? i_data_from_memory[31:16] : i_data_from_memory[15:0];
    case (funct3)
      3'b000:  ld_res = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_res = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_res = {24'b0, ld_byte};
      3'b101:  ld_res = {16'b0, ld_half};
      default: ld_res = i_data_from_memory;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << byte_off;
        st_data = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        st_mask = byte_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = rs2_val;
      end
    endcase
  end

  assign i_inst_addr       = pc_q;
  assign o_store_data_addr = mem_addr;
  assign o_store_data      = st_data;
  assign o_wr_en           = i_rst_n & (opcode == OPC_STORE);
  assign o_wr_mask         = o_wr_en ? st_mask : '0;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d     = pc_plus4;
    rd_we    = 1'b0;
    rd_wdata = '0;
    case (opcode)
      OPC_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OPC_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OPC_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = {mem_addr[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OPC_LOAD: begin
        rd_we    = 1'b1;
        rd_wdata = ld_res;
      end
      OPC_OPIMM, OPC_OP: begin
        rd_we    = 1'b1;
        rd_wdata = alu_res;
      end
      default: ;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (rd_we && rd != 5'd0) regs_d[rd] = rd_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pc_q <= PC_RESET;
    else          pc_q <= pc_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_asrv32_core.sv
// Bench for asrv32_core: directed vector tables with constant expectations,
// then random instructions checked against an instruction-level model.
module tb_asrv32_core;

  localparam int OPC_LUI   = 'h37;
  localparam int OPC_AUIPC = 'h17;
  localparam int OPC_JALR  = 'h67;
  localparam int OPC_LOAD  = 'h03;
  localparam int OPC_OPIMM = 'h13;
  localparam int OPC_STORE = 'h23;
  localparam int OPC_OP    = 'h33;
  localparam int OPC_BR    = 'h63;
  localparam int OPC_JAL   = 'h6F;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [31:0] i_inst = 32'h0000_0013;
  logic [31:0] i_inst_addr;
  logic [31:0] i_data_from_memory;
  logic [31:0] o_store_data;
  logic [31:0] o_store_data_addr;
  logic [3:0]  o_wr_mask;
  logic        o_wr_en;

  asrv32_core #(.PC_RESET(32'h0000_0000)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_inst             (i_inst),
    .i_inst_addr        (i_inst_addr),
    .i_data_from_memory (i_data_from_memory),
    .o_store_data       (o_store_data),
    .o_store_data_addr  (o_store_data_addr),
    .o_wr_mask          (o_wr_mask),
    .o_wr_en            (o_wr_en)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [1024];
  assign i_data_from_memory = mem[o_store_data_addr[11:2]];

  logic [31:0] m_x [32];
  logic [31:0] m_pc;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ld;
    logic [31:0] npc;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] rdv;
  } exp_t;

  vec_t tab[$];

  function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1, int imm);
    logic [31:0] m = imm;
    return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(int f3, int rs2, int rs1, int imm);
    logic [31:0] m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    logic [31:0] m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(int op, int rd, int imm20);
    logic [31:0] m = imm20;
    return {m[19:0], 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_j(int rd, int imm);
    logic [31:0] m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic vec_t nv(logic [31:0] ins, logic [31:0] pc);
    vec_t v;
    v.rst = 1'b0; v.ins = ins; v.pc = pc; v.st = 1'b0;
    v.addr = '0; v.mask = '0; v.data = '0;
    return v;
  endfunction

  function automatic vec_t sv(logic [31:0] ins, logic [31:0] pc, logic [31:0] addr,
                              logic [3:0] mask, logic [31:0] data);
    vec_t v;
    v.rst = 1'b0; v.ins = ins; v.pc = pc; v.st = 1'b1;
    v.addr = addr; v.mask = mask; v.data = data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Instruction-level model: effect of one instruction on the architectural state
  task automatic predict(input logic [31:0] ins, output exp_t e);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] r1, r2, imm_i, imm_s, imm_b, imm_j, imm_u, w, bsh, hsh, opb, res;
    logic        tk;
    op    = ins[6:0];
    f3    = ins[14:12];
    r1    = m_x[ins[19:15]];
    r2    = m_x[ins[24:20]];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    imm_u = {ins[31:12], 12'h000};
    e.pc = m_pc; e.we = 1'b0; e.mask = '0; e.addr = '0; e.data = '0; e.ld = 1'b0;
    e.npc = m_pc + 4; e.rwe = 1'b0; e.rd = ins[11:7]; e.rdv = '0;
    case (int'(op))
      OPC_LUI:   begin e.rwe = 1'b1; e.rdv = imm_u; end
      OPC_AUIPC: begin e.rwe = 1'b1; e.rdv = m_pc + imm_u; end
      OPC_JAL:   begin e.rwe = 1'b1; e.rdv = m_pc + 4; e.npc = m_pc + imm_j; end
      OPC_JALR:  begin e.rwe = 1'b1; e.rdv = m_pc + 4; e.npc = (r1 + imm_i) & ~32'h1; end
      OPC_BR: begin
        case (f3)
          3'd0:    tk = (r1 == r2);
          3'd1:    tk = (r1 != r2);
          3'd4:    tk = ($signed(r1) <  $signed(r2));
          3'd5:    tk = ($signed(r1) >= $signed(r2));
          3'd6:    tk = (r1 <  r2);
          3'd7:    tk = (r1 >= r2);
          default: tk = 1'b0;
        endcase
        if (tk) e.npc = m_pc + imm_b;
      end
      OPC_LOAD: begin
        e.ld   = 1'b1;
        e.addr = r1 + imm_i;
        w      = mem[e.addr[11:2]];
        bsh    = w >> (8 * e.addr[1:0]);
        hsh    = w >> (16 * e.addr[1]);
        e.rwe  = 1'b1;
        case (f3)
          3'd0:    e.rdv = 32'($signed(bsh[7:0]));
          3'd1:    e.rdv = 32'($signed(hsh[15:0]));
          3'd4:    e.rdv = {24'h0, bsh[7:0]};
          3'd5:    e.rdv = {16'h0, hsh[15:0]};
          default: e.rdv = w;
        endcase
      end
      OPC_STORE: begin
        e.we   = 1'b1;
        e.addr = r1 + imm_s;
        case (f3)
          3'd0:    begin e.mask = 4'b0001 << e.addr[1:0]; e.data = {4{r2[7:0]}}; end
          3'd1:    begin e.mask = 4'b0011 << (2 * e.addr[1]); e.data = {2{r2[15:0]}}; end
          default: begin e.mask = 4'b1111; e.data = r2; end
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        opb = (int'(op) == OPC_OP) ? r2 : imm_i;
        case (f3)
          3'd0: res = (int'(op) == OPC_OP && ins[30]) ? r1 - opb : r1 + opb;
          3'd1: res = r1 << opb[4:0];
          3'd2: res = ($signed(r1) < $signed(opb)) ? 32'd1 : 32'd0;
          3'd3: res = (r1 < opb) ? 32'd1 : 32'd0;
          3'd4: res = r1 ^ opb;
          3'd5: begin
            if (ins[30]) res = $signed(r1) >>> opb[4:0];
            else         res = r1 >> opb[4:0];
          end
          3'd6: res = r1 | opb;
          default: res = r1 & opb;
        endcase
        e.rwe = 1'b1;
        e.rdv = res;
      end
      default: ;
    endcase
  endtask

  task automatic commit(input exp_t e);
    if (e.rwe && e.rd != 5'd0) m_x[e.rd] = e.rdv;
    if (e.we) begin
      for (int n = 0; n < 4; n++)
        if (e.mask[n]) mem[e.addr[11:2]][8*n +: 8] = e.data[8*n +: 8];
    end
    m_pc = e.npc;
  endtask

  task automatic exec(input vec_t v, input logic tabchk);
    exp_t e;
    @(negedge i_clk);
    i_inst = v.ins;
    #1;
    predict(v.ins, e);
    chk("pc", i_inst_addr, e.pc);
    chk("wr_en", 32'(o_wr_en), 32'(e.we));
    chk("wr_mask", 32'(o_wr_mask), 32'(e.mask));
    if (e.we) begin
      chk("st_addr", o_store_data_addr, e.addr);
      chk("st_data", o_store_data, e.data);
    end
    if (e.ld) chk("ld_addr", o_store_data_addr, e.addr);
    if (tabchk) begin
      chk("tab_pc", i_inst_addr, v.pc);
      chk("tab_wr_en", 32'(o_wr_en), 32'(v.st));
      chk("tab_wr_mask", 32'(o_wr_mask), 32'(v.mask));
      if (v.st) begin
        chk("tab_st_addr", o_store_data_addr, v.addr);
        chk("tab_st_data", o_store_data, v.data);
      end
    end
    @(posedge i_clk);
    #1;
    commit(e);
  endtask

  // Reset asserted mid-cycle while a store is presented
  task automatic do_reset();
    @(negedge i_clk);
    i_inst = enc_s(2, 1, 0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_pc", i_inst_addr, 32'h0);
    chk("rst_wr_en", 32'(o_wr_en), 32'h0);
    chk("rst_wr_mask", 32'(o_wr_mask), 32'h0);
    @(posedge i_clk);
    #1;
    chk("rst_pc_hold", i_inst_addr, 32'h0);
    i_rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m_x[r] = '0;
    m_pc = 32'h0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0]  nop_op [4] = '{7'h0F, 7'h73, 7'h00, 7'h7F};
    int unsigned k;
    int          rd, r1, r2, f3, f7, sh;
    logic [31:0] ins;
    k  = $urandom_range(0, 11);
    rd = int'($urandom_range(0, 31));
    r1 = int'($urandom_range(0, 31));
    r2 = int'($urandom_range(0, 31));
    sh = int'($urandom_range(0, 31));
    case (k)
      0: ins = enc_u(OPC_LUI, rd, int'($urandom));
      1: ins = enc_u(OPC_AUIPC, rd, int'($urandom));
      2: ins = enc_j(rd, int'($urandom & 32'h001F_FFFE));
      3: ins = enc_i(OPC_JALR, 0, rd, r1, int'($urandom));
      4: ins = enc_b(int'(br_f3[$urandom_range(0, 5)]), r1, r2, int'($urandom & 32'h0000_1FFE));
      5: ins = enc_i(OPC_LOAD, int'(ld_f3[$urandom_range(0, 4)]), rd, r1, int'($urandom));
      6: ins = enc_s(int'($urandom_range(0, 2)), r2, r1, int'($urandom));
      7, 8: begin
        f3 = int'($urandom_range(0, 7));
        if (f3 == 1)      ins = enc_i(OPC_OPIMM, f3, rd, r1, sh);
        else if (f3 == 5) ins = enc_i(OPC_OPIMM, f3, rd, r1, ($urandom_range(0, 1) == 1 ? 'h400 : 0) + sh);
        else              ins = enc_i(OPC_OPIMM, f3, rd, r1, int'($urandom));
      end
      9, 10: begin
        f3 = int'($urandom_range(0, 7));
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 'h20 : 0;
        ins = enc_r(f7, f3, rd, r1, r2);
      end
      default: begin
        ins      = $urandom;
        ins[6:0] = nop_op[$urandom_range(0, 3)];
      end
    endcase
    return ins;
  endfunction

  initial begin
    vec_t v;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int r = 0; r < 32; r++) m_x[r] = '0;
    m_pc = '0;

    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 1, 0, -1), 32'h00));
    tab.push_back(nv(enc_i(OPC_OPIMM, 5, 2, 1, 28), 32'h04));
    tab.push_back(nv(enc_i(OPC_OPIMM, 5, 3, 1, 'h404), 32'h08));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 0, 0, 5), 32'h0C));
    tab.push_back(sv(enc_s(2, 1, 0, 0), 32'h10, 32'h0, 4'hF, 32'hFFFF_FFFF));
    tab.push_back(sv(enc_s(2, 2, 0, 4), 32'h14, 32'h4, 4'hF, 32'h0000_000F));
    tab.push_back(sv(enc_s(2, 3, 0, 8), 32'h18, 32'h8, 4'hF, 32'hFFFF_FFFF));
    tab.push_back(sv(enc_s(2, 0, 0, 12), 32'h1C, 32'hC, 4'hF, 32'h0));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 5, 0, 'h100), 32'h20));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 6, 0, 'hA5), 32'h24));
    tab.push_back(sv(enc_s(0, 6, 5, 1), 32'h28, 32'h101, 4'b0010, 32'hA5A5_A5A5));
    tab.push_back(nv(enc_i(OPC_LOAD, 0, 7, 5, 1), 32'h2C));
    tab.push_back(sv(enc_s(2, 7, 0, 0), 32'h30, 32'h0, 4'hF, 32'hFFFF_FFA5));
    tab.push_back(nv(enc_i(OPC_LOAD, 4, 7, 5, 1), 32'h34));
    tab.push_back(sv(enc_s(2, 7, 0, 0), 32'h38, 32'h0, 4'hF, 32'h0000_00A5));
    tab.push_back(nv(enc_u(OPC_LUI, 8, 'h12345), 32'h3C));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 8, 8, 'h678), 32'h40));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 9, 0, 'h200), 32'h44));
    tab.push_back(sv(enc_s(2, 8, 9, 0), 32'h48, 32'h200, 4'hF, 32'h1234_5678));
    tab.push_back(nv(enc_i(OPC_LOAD, 1, 10, 9, 2), 32'h4C));
    tab.push_back(nv(enc_i(OPC_LOAD, 5, 11, 9, 0), 32'h50));
    tab.push_back(sv(enc_s(2, 10, 0, 0), 32'h54, 32'h0, 4'hF, 32'h0000_1234));
    tab.push_back(sv(enc_s(2, 11, 0, 4), 32'h58, 32'h4, 4'hF, 32'h0000_5678));
    tab.push_back(sv(enc_s(1, 6, 9, 3), 32'h5C, 32'h203, 4'b1100, 32'h00A5_00A5));
    tab.push_back(nv(enc_i(OPC_LOAD, 2, 12, 9, 0), 32'h60));
    tab.push_back(sv(enc_s(2, 12, 0, 0), 32'h64, 32'h0, 4'hF, 32'h00A5_5678));
    tab.push_back(nv(enc_u(OPC_LUI, 4, 'h12345), 32'h68));
    tab.push_back(sv(enc_s(2, 4, 0, 0), 32'h6C, 32'h0, 4'hF, 32'h1234_5000));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 13, 0, -5), 32'h70));
    tab.push_back(nv(enc_i(OPC_OPIMM, 2, 14, 13, 3), 32'h74));
    tab.push_back(nv(enc_i(OPC_OPIMM, 3, 15, 13, 3), 32'h78));
    tab.push_back(nv(enc_r('h20, 0, 16, 0, 1), 32'h7C));
    tab.push_back(sv(enc_s(2, 14, 0, 0), 32'h80, 32'h0, 4'hF, 32'h1));
    tab.push_back(sv(enc_s(2, 15, 0, 4), 32'h84, 32'h4, 4'hF, 32'h0));
    tab.push_back(sv(enc_s(2, 16, 0, 8), 32'h88, 32'h8, 4'hF, 32'h1));
    tab.push_back(nv(32'hFFFF_FFFF, 32'h8C));
    tab.push_back(nv(32'h0000_0073, 32'h90));
    tab.push_back(nv(32'h0000_000F, 32'h94));
    tab.push_back(sv(enc_s(2, 31, 0, 0), 32'h98, 32'h0, 4'hF, 32'h0));

    v = nv(enc_i(OPC_OPIMM, 0, 20, 0, 1), 32'h00);
    v.rst = 1'b1;
    tab.push_back(v);
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 20, 0, 2), 32'h04));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 20, 0, 3), 32'h08));
    tab.push_back(nv(enc_i(OPC_OPIMM, 0, 21, 0, 4), 32'h0C));
    tab.push_back(nv(enc_b(1, 0, 0, 8), 32'h10));
    tab.push_back(nv(enc_j(0, -4), 32'h14));
    tab.push_back(nv(enc_b(0, 0, 0, 8), 32'h10));
    tab.push_back(nv(enc_j(0, 'h28), 32'h18));
    tab.push_back(nv(enc_j(1, 'h20), 32'h40));
    tab.push_back(nv(enc_i(OPC_JALR, 0, 0, 1, 1), 32'h60));
    tab.push_back(sv(enc_s(2, 1, 0, 0), 32'h44, 32'h0, 4'hF, 32'h44));
    tab.push_back(nv(enc_j(0, 'h38), 32'h48));
    tab.push_back(nv(enc_u(OPC_AUIPC, 4, 1), 32'h80));
    tab.push_back(sv(enc_s(2, 4, 0, 0), 32'h84, 32'h0, 4'hF, 32'h1080));
    tab.push_back(nv(enc_b(4, 21, 20, 16), 32'h88));
    tab.push_back(nv(enc_b(7, 21, 20, -8), 32'h8C));
    tab.push_back(sv(enc_s(2, 20, 0, 0), 32'h84, 32'h0, 4'hF, 32'h3));

    do_reset();
    foreach (tab[i]) begin
      if (tab[i].rst) do_reset();
      exec(tab[i], 1'b1);
    end

    for (int n = 0; n < 600; n++) exec(nv(rand_inst(), 32'h0), 1'b0);

    for (int r = 1; r < 32; r++) exec(nv(enc_s(2, r, 0, 0), 32'h0), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
